// File: rtl/seq_restoring_divider_pkg.sv
// Shared arithmetic package: control-state encodings and counter sizing helper,
// common to the sequential divider and the shift-add multiplier control units.
package seq_arith_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StSub   = 2'd2
  } arith_state_e;

  // Width of a down-counter that must hold the value `width` itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle of the sequential divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 5
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_control_unit.sv
// Control FSM of the restoring divider: sequences load, shift and subtract steps
// and produces the ready/done handshake.
module divider_control_unit
  import seq_arith_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic div0,
  input  logic zero,
  input  logic ge,
  output logic ready,
  output logic load_reg,
  output logic shift_reg,
  output logic sub_reg,
  output logic dec_p,
  output logic done
);

  arith_state_e r_state;
  logic         r_ready;
  logic         r_done;
  logic         r_shift;
  logic         r_sub;

  // State and registered step strobes; strobes reflect the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_shift <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            if (div0) begin
              // Result is forced in the datapath; only the done pulse is needed.
              r_done <= 1'b1;
            end else begin
              r_state <= StShift;
              r_ready <= 1'b0;
              r_shift <= 1'b1;
            end
          end
        end
        StShift: begin
          r_state <= StSub;
          r_shift <= 1'b0;
          r_sub   <= 1'b1;
        end
        StSub: begin
          r_sub <= 1'b0;
          if (zero) begin
            r_state <= StIdle;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_state <= StShift;
            r_shift <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
          r_shift <= 1'b0;
          r_sub   <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign load_reg  = r_ready & start;
  assign shift_reg = r_shift;
  assign dec_p     = r_shift;
  // The shift already cleared Q[0], so a SUB step only acts when A >= B.
  assign sub_reg   = r_sub & ge;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per shift/subtract pair.
// Holds the A/Q/B/P datapath; sequencing comes from divider_control_unit.
module seq_restoring_divider
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  seq_restoring_divider_if.slave  bus
);

  localparam int unsigned PW = cnt_width(WIDTH);

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_b;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_hold_q;
  logic [WIDTH-1:0] r_hold_r;
  logic             r_dbz;

  logic             w_div0;
  logic             w_zero;
  logic             w_ge;
  logic [WIDTH:0]   w_diff;
  logic             w_ready;
  logic             w_load;
  logic             w_shift;
  logic             w_sub;
  logic             w_dec_p;
  logic             w_done;

  assign w_div0 = (bus.divisor == '0);
  assign w_zero = (r_p == '0);
  assign w_ge   = (r_a >= r_b);
  assign w_diff = r_a - r_b;

  divider_control_unit u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (bus.start),
    .div0     (w_div0),
    .zero     (w_zero),
    .ge       (w_ge),
    .ready    (w_ready),
    .load_reg (w_load),
    .shift_reg(w_shift),
    .sub_reg  (w_sub),
    .dec_p    (w_dec_p),
    .done     (w_done)
  );

  // Datapath: operand load, {A,Q} shift, conditional subtract, bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_hold_q <= '0;
      r_hold_r <= '0;
      r_dbz    <= 1'b0;
    end else if (w_load) begin
      // Snapshot the current result so the outputs stay put while busy.
      r_hold_q <= r_q;
      r_hold_r <= r_a[WIDTH-1:0];
      if (w_div0) begin
        r_a   <= {1'b0, bus.dividend};
        r_q   <= '1;
        r_dbz <= 1'b1;
      end else begin
        r_a   <= '0;
        r_q   <= bus.dividend;
        r_b   <= {1'b0, bus.divisor};
        r_p   <= PW'(WIDTH);
        r_dbz <= 1'b0;
      end
    end else begin
      if (w_shift) begin
        {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
      end else if (w_sub) begin
        r_a    <= w_diff;
        r_q[0] <= 1'b1;
      end
      if (w_dec_p) begin
        r_p <= r_p - PW'(1);
      end
    end
  end

  assign bus.ready       = w_ready;
  assign bus.done        = w_done;
  assign bus.div_by_zero = r_dbz;
  // Live registers are the result only in IDLE; otherwise show the snapshot.
  assign bus.quotient    = w_ready ? r_q : r_hold_q;
  assign bus.remainder   = w_ready ? r_a[WIDTH-1:0] : r_hold_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus an exhaustive
// operand sweep with random busy-time noise, checked against integer / and %.
module tb_seq_restoring_divider;

  localparam int unsigned W = 5;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int unsigned      n_vec = 0;
  int unsigned      n_bad = 0;
  logic [W-1:0]     prev_q = '0;
  logic [W-1:0]     prev_r = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One division starting at a negedge with ready high; returns at the done negedge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    int unsigned  busy;
    int unsigned  hold_err;
    string        op;
    op = $sformatf("%0d/%0d", a, b);
    if (b == '0) begin
      eq = '1;
      er = a;
      edbz = 1'b1;
    end else begin
      eq = a / b;
      er = a % b;
      edbz = 1'b0;
    end
    check_eq({"ready_before ", op}, 32'(bus.ready), 32'd1);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    busy = 0;
    hold_err = 0;
    while (!bus.ready && busy < 100) begin
      if (bus.done !== 1'b0 || bus.quotient !== prev_q || bus.remainder !== prev_r)
        hold_err++;
      if (noise) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.dividend = W'($urandom_range(0, 31));
        bus.divisor  = W'($urandom_range(0, 31));
      end else begin
        bus.start = 1'b0;
      end
      busy++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq({"busy_cycles ", op}, busy, (b == '0) ? 32'd0 : 32'(2 * W));
    check_eq({"hold_while_busy ", op}, hold_err, 32'd0);
    check_eq({"done ", op}, 32'(bus.done), 32'd1);
    check_eq({"quotient ", op}, 32'(bus.quotient), 32'(eq));
    check_eq({"remainder ", op}, 32'(bus.remainder), 32'(er));
    check_eq({"div_by_zero ", op}, 32'(bus.div_by_zero), 32'(edbz));
    prev_q = eq;
    prev_r = er;
  endtask

  // One idle cycle after a result; done must have been a single-cycle pulse.
  task automatic gap();
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("done_pulse_width", 32'(bus.done), 32'd0);
    check_eq("ready_idle", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int unsigned ndone;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_ready", 32'(bus.ready), 32'd1);
    check_eq("reset_done", 32'(bus.done), 32'd0);
    check_eq("reset_quotient", 32'(bus.quotient), 32'd0);
    check_eq("reset_remainder", 32'(bus.remainder), 32'd0);
    check_eq("reset_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(5'd13, 5'd4, 1'b0);  gap();
    run_op(5'd31, 5'd1, 1'b0);  gap();
    run_op(5'd7,  5'd9, 1'b0);  gap();
    run_op(5'd0,  5'd5, 1'b0);  gap();
    run_op(5'd17, 5'd0, 1'b0);  gap();
    run_op(5'd30, 5'd7, 1'b0);  gap();
    // Busy-time start pulses and operand changes must be ignored.
    run_op(5'd25, 5'd3, 1'b1);
    // Back-to-back: new start presented on the done cycle.
    run_op(5'd29, 5'd6, 1'b0);
    run_op(5'd31, 5'd0, 1'b0);
    run_op(5'd19, 5'd2, 1'b0);  gap();

    // Reset in the middle of 22/5 aborts without a done pulse.
    bus.start    = 1'b1;
    bus.dividend = 5'd22;
    bus.divisor  = 5'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'(bus.ready), 32'd1);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_quotient", 32'(bus.quotient), 32'd0);
    check_eq("abort_remainder", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_q = '0;
    prev_r = '0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done !== 1'b0) ndone++;
    end
    check_eq("abort_no_done", ndone, 32'd0);
    run_op(5'd22, 5'd5, 1'b0);  gap();

    // Every operand pair, with random noise and random back-to-back spacing.
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        run_op(W'(a), W'(b), ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) gap();
      end
    end

    for (int i = 0; i < 100; i++) begin
      run_op(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)), 1'b1);
    end
    gap();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
